spi_rx_param: RTL and testbench

SPI_RX_PARAM -- requirements
Module: spi_rx_param

---
 rtl/spi_rx_param.sv | 129 ++++++++++++
 tb/tb_spi_rx_param.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_rx_param.sv
// spi_rx_param: SPI receiver (slave, receive only) with run-time mode select and a valid/ready output.
// Ports:
//   clk        system clock; all logic runs on the rising edge
//   rst        synchronous, active-low reset
//   sclk       asynchronous SPI clock input
//   ss_n       asynchronous SPI select input, active low
//   mosi       asynchronous SPI data input
//   cpol       clock polarity; latched when a frame starts
//   cpha       clock phase; latched when a frame starts
//   lsbfe      1 = first bit received lands in bit 0; latched when a frame starts
//   rx_data    last completed word
//   rx_valid   rx_data holds a word that has not been consumed yet
//   rx_ready   consumer takes rx_data when rx_valid and rx_ready are both high
//   overrun    one-cycle pulse when a word completes while the previous one is unconsumed
//   frame_err  one-cycle pulse when ss_n rises part-way through a word
//   busy       high while a frame is being received
module spi_rx_param #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              ss_n,
    input  logic              mosi,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsbfe,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              overrun,
    output logic              frame_err,
    output logic              busy
);
    localparam int CW = $clog2(DATA_W);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] sclk_q, ss_q, mosi_q, live;
    logic                   sclk_p, ss_p, armed;
    logic                   cpol_l, cpha_l, lsb_l;
    logic [DATA_W-1:0]      sh, sh_n;
    logic [CW-1:0]          cnt;
    logic                   sclk_s, ss_s, mosi_s;
    logic                   sample, last, done, ss_fall, ss_rise;

    assign sclk_s = sclk_q[SYNC_STAGES-1];
    assign ss_s   = ss_q[SYNC_STAGES-1];
    assign mosi_s = mosi_q[SYNC_STAGES-1];
    assign busy   = state == SHIFT;

    // live fills with ones after reset so armed only sets once ss_s carries a real
    // high sample; a select held low through reset therefore cannot start a frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sclk_q <= '0;
            ss_q   <= '1;
            mosi_q <= '0;
            live   <= '0;
            sclk_p <= 1'b0;
            ss_p   <= 1'b1;
            armed  <= 1'b0;
        end else begin
            sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
            ss_q   <= {ss_q[SYNC_STAGES-2:0], ss_n};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
            live   <= {live[SYNC_STAGES-2:0], 1'b1};
            sclk_p <= sclk_s;
            ss_p   <= ss_s;
            armed  <= armed | (live[SYNC_STAGES-1] & ss_s);
        end
    end

    // Sample on the rising edge when cpol == cpha, otherwise on the falling edge.
    always_comb begin
        sample  = busy & ((cpol_l == cpha_l) ? (sclk_s & ~sclk_p) : (~sclk_s & sclk_p));
        last    = cnt == CW'(DATA_W - 1);
        done    = sample & last;
        ss_fall = armed & ss_p & ~ss_s;
        ss_rise = busy & ~ss_p & ss_s;
        sh_n    = lsb_l ? {mosi_s, sh[DATA_W-1:1]} : {sh[DATA_W-2:0], mosi_s};
        state_n = (state == IDLE) ? (ss_fall ? SHIFT : IDLE) : (ss_rise ? IDLE : SHIFT);
    end

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cpol_l    <= 1'b0;
            cpha_l    <= 1'b0;
            lsb_l     <= 1'b0;
            sh        <= '0;
            cnt       <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= done & rx_valid & ~rx_ready;
            frame_err <= ss_rise & ~done & (cnt != '0);
            if (state == IDLE && ss_fall) begin
                cpol_l <= cpol;
                cpha_l <= cpha;
                lsb_l  <= lsbfe;
            end
            if (ss_rise) begin
                cnt <= '0;
                sh  <= '0;
            end else if (sample) begin
                cnt <= last ? '0 : cnt + 1'b1;
                sh  <= sh_n;
            end
            // A completing word is still delivered when ss_n rises in the same cycle.
            if (done && (!rx_valid || rx_ready)) begin
                rx_data  <= sh_n;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_spi_rx_param.sv
// tb_spi_rx_param: table-driven and scoreboard checks of spi_rx_param at DATA_W 8 and 16.
module tb_spi_rx_param;
    logic        clk = 0, rst = 0, sclk = 0, mosi = 0, cpol = 0, cpha = 0, lsbfe = 0, rdy = 1;
    logic        ss8 = 1, ss16 = 1;
    logic [7:0]  d8;
    logic [15:0] d16;
    logic        v8, ov8, fe8, b8, v16, ov16, fe16, b16;
    logic        m_cpol = 0, m_cpha = 0, sel16 = 0;
    logic        pv8 = 0, pv16 = 0;
    int          cmp = 0, mism = 0, ov_hi = 0, fe_hi = 0;
    logic [7:0]  q8[$];
    logic [15:0] q16[$];

    typedef struct {
        logic       cpol, cpha, lsb, flip;
        logic [7:0] data, exp;
    } vec_t;

    always #5 clk = ~clk;

    spi_rx_param #(.DATA_W(8)) u8 (
        .clk(clk), .rst(rst), .sclk(sclk), .ss_n(ss8), .mosi(mosi), .cpol(cpol), .cpha(cpha),
        .lsbfe(lsbfe), .rx_data(d8), .rx_valid(v8), .rx_ready(rdy), .overrun(ov8),
        .frame_err(fe8), .busy(b8));

    spi_rx_param #(.DATA_W(16)) u16 (
        .clk(clk), .rst(rst), .sclk(sclk), .ss_n(ss16), .mosi(mosi), .cpol(cpol), .cpha(cpha),
        .lsbfe(lsbfe), .rx_data(d16), .rx_valid(v16), .rx_ready(rdy), .overrun(ov16),
        .frame_err(fe16), .busy(b16));

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        cmp++;
        if (got !== exp) begin
            mism++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ss(input logic v);
        if (sel16) ss16 = v;
        else ss8 = v;
    endtask

    task automatic tog(input bit lat);
        sclk = ~sclk;
        if (lat) begin
            cyc(2);
            chk("lat_before", sel16 ? v16 : v8, 0);
            cyc(1);
            chk("lat_rise", sel16 ? v16 : v8, 1);
            cyc(1);
            chk("lat_pulse", sel16 ? v16 : v8, 0);
        end
    endtask

    task automatic send_bits(input logic [31:0] w, input int n, input bit lsb, input bit lat, input bit flip);
        for (int i = 0; i < n; i++) begin
            logic b;
            b = lsb ? w[i] : w[n-1-i];
            if (flip && i == 3) begin
                cpha  = ~cpha;
                lsbfe = ~lsbfe;
            end
            if (!m_cpha) mosi = b;
            cyc(4);
            tog(lat && i == n - 1 && !m_cpha);
            if (m_cpha) mosi = b;
            cyc(4);
            tog(lat && i == n - 1 && m_cpha);
        end
    endtask

    task automatic begin_f(input bit lsb);
        cpol  = m_cpol;
        cpha  = m_cpha;
        lsbfe = lsb;
        sclk  = m_cpol;
        cyc(4);
        set_ss(0);
        cyc(4);
    endtask

    task automatic end_f();
        cyc(4);
        set_ss(1);
        cyc(6);
    endtask

    task automatic frame(input logic [31:0] w, input int n, input bit lsb, input bit lat, input bit flip);
        begin_f(lsb);
        send_bits(w, n, lsb, lat, flip);
        end_f();
    endtask

    // A new word appears when rx_valid rises, or stays high across an accepting edge.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            pv8  = 0;
            pv16 = 0;
        end else begin
            if (v8 && (!pv8 || rdy)) begin
                cmp++;
                if (q8.size() == 0) begin
                    mism++;
                    $display("FAIL sb8 unexpected word: got %0h expected none", d8);
                end else begin
                    logic [7:0] e;
                    e = q8.pop_front();
                    if (d8 !== e) begin
                        mism++;
                        $display("FAIL sb8 word: got %0h expected %0h", d8, e);
                    end
                end
            end
            if (v16 && (!pv16 || rdy)) begin
                cmp++;
                if (q16.size() == 0) begin
                    mism++;
                    $display("FAIL sb16 unexpected word: got %0h expected none", d16);
                end else begin
                    logic [15:0] e;
                    e = q16.pop_front();
                    if (d16 !== e) begin
                        mism++;
                        $display("FAIL sb16 word: got %0h expected %0h", d16, e);
                    end
                end
            end
            ov_hi += int'(ov8) + int'(ov16);
            fe_hi += int'(fe8) + int'(fe16);
            pv8  = v8;
            pv16 = v16;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[6];
        tbl[0] = '{0, 0, 0, 0, 8'hA5, 8'hA5};
        tbl[1] = '{0, 1, 1, 0, 8'h01, 8'h01};
        tbl[2] = '{1, 0, 1, 0, 8'h01, 8'h01};
        tbl[3] = '{1, 1, 1, 0, 8'h01, 8'h01};
        tbl[4] = '{1, 1, 0, 0, 8'h5A, 8'h5A};
        tbl[5] = '{0, 0, 0, 1, 8'hC3, 8'hC3};

        cyc(3);
        chk("rst_data", {d16, d8}, 0);
        chk("rst_flags", {v8, ov8, fe8, b8, v16, ov16, fe16, b16}, 0);
        rst = 1;
        cyc(4);

        for (int i = 0; i < 6; i++) begin
            m_cpol = tbl[i].cpol;
            m_cpha = tbl[i].cpha;
            q8.push_back(tbl[i].exp);
            frame({24'd0, tbl[i].data}, 8, tbl[i].lsb, i == 0, tbl[i].flip);
            chk($sformatf("tbl%0d_data", i), d8, tbl[i].exp);
            chk($sformatf("tbl%0d_valid", i), v8, 0);
            chk($sformatf("tbl%0d_busy", i), b8, 0);
        end
        chk("tbl_errs", ov_hi + fe_hi, 0);

        m_cpol = 0;
        m_cpha = 0;
        sel16  = 1;
        q16.push_back(16'h1234);
        q16.push_back(16'hBEEF);
        begin_f(0);
        send_bits(32'h1234, 16, 0, 0, 0);
        chk("b2b_busy", b16, 1);
        send_bits(32'hBEEF, 16, 0, 0, 0);
        end_f();
        chk("b2b_data", d16, 16'hBEEF);
        chk("b2b_errs", ov_hi + fe_hi, 0);
        sel16 = 0;

        rdy = 0;
        q8.push_back(8'h11);
        frame(32'h11, 8, 0, 0, 0);
        frame(32'h22, 8, 0, 0, 0);
        chk("ovr_data", d8, 8'h11);
        chk("ovr_valid", v8, 1);
        chk("ovr_pulse", ov_hi, 1);
        rdy = 1;
        cyc(2);
        chk("ovr_drain", v8, 0);
        ov_hi = 0;

        begin_f(0);
        send_bits(32'h1F, 5, 0, 0, 0);
        end_f();
        chk("ferr_pulse", fe_hi, 1);
        chk("ferr_valid", v8, 0);
        q8.push_back(8'h3C);
        frame(32'h3C, 8, 0, 0, 0);
        chk("ferr_next", d8, 8'h3C);
        chk("ferr_once", fe_hi, 1);
        fe_hi = 0;

        q8.push_back(8'h96);
        begin_f(0);
        send_bits(32'h4B, 7, 0, 0, 0);
        mosi = 0;
        cyc(4);
        sclk = 1;
        ss8  = 1;
        cyc(6);
        sclk = 0;
        cyc(6);
        chk("last_ss_data", d8, 8'h96);
        chk("last_ss_ferr", fe_hi, 0);
        chk("last_ss_busy", b8, 0);

        begin_f(0);
        send_bits(32'h5, 3, 0, 0, 0);
        rst = 0;
        cyc(3);
        chk("mid_rst", {d8, v8, b8}, 0);
        rst = 1;
        cyc(8);
        chk("no_restart", b8, 0);
        ss8 = 1;
        cyc(6);
        q8.push_back(8'hF0);
        frame(32'hF0, 8, 0, 0, 0);
        chk("rst_frame", d8, 8'hF0);
        chk("rst_ferr", fe_hi, 0);

        chk("sb8_empty", q8.size(), 0);
        chk("sb16_empty", q16.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
        $finish;
    end
endmodule
